// File: rtl/pid_multi_channel.sv
// Time-multiplexed PID controller serving N_CH pressure loops in 6-cycle channel slots.
// A single signed multiplier is shared across the P, I and D phases of every slot.
module pid_multi_channel #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int N_CH = 4,
  parameter int FRAC_BITS = 7,
  parameter logic signed [DATA_W-1:0] INT_LIM = 16'sd20000,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     sample_tick,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH*DATA_W-1:0]   setpoint,
  input  logic [N_CH*DATA_W-1:0]   meas,
  input  logic signed [COEF_W-1:0] kp,
  input  logic signed [COEF_W-1:0] ki,
  input  logic signed [COEF_W-1:0] kd,
  input  logic signed [DATA_W-1:0] out_min,
  input  logic signed [DATA_W-1:0] out_max,
  output logic [N_CH*DATA_W-1:0]   pid_out,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PROD_W = COEF_W + DATA_W + 1;
  localparam int SUM_W  = DATA_W + COEF_W + 2;
  localparam logic signed [DATA_W-1:0] D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] NEG_LIM = -INT_LIM;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_P    = 3'd2,
    S_I    = 3'd3,
    S_D    = 3'd4,
    S_SUM  = 3'd5,
    S_WR   = 3'd6
  } state_t;

  state_t                    state_r;
  logic [CH_W-1:0]           ch_r;
  logic                      en_r;
  logic signed [DATA_W-1:0]  err_r;
  logic signed [DATA_W-1:0]  icand_r;
  logic signed [DATA_W-1:0]  sum_r;
  logic signed [PROD_W-1:0]  p_r;
  logic signed [PROD_W-1:0]  d_r;
  logic                      sat_hi_r;
  logic                      sat_lo_r;
  logic signed [DATA_W-1:0]  integ_r    [N_CH];
  logic signed [DATA_W-1:0]  prev_err_r [N_CH];
  logic signed [DATA_W-1:0]  pid_r      [N_CH];

  logic [DATA_W-1:0]         sp_a [N_CH];
  logic [DATA_W-1:0]         ms_a [N_CH];
  logic [DATA_W-1:0]         sp_s;
  logic [DATA_W-1:0]         ms_s;
  logic                      en_s;
  logic signed [DATA_W-1:0]  integ_s;
  logic signed [DATA_W-1:0]  prev_s;
  logic signed [DATA_W:0]    err_full_s;
  logic signed [DATA_W:0]    diff_s;
  logic signed [COEF_W-1:0]  mul_a_s;
  logic signed [DATA_W:0]    mul_b_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [PROD_W-1:0]  shift_s;
  logic signed [PROD_W:0]    icand_full_s;
  logic signed [SUM_W-1:0]   sum_s;
  logic                      hold_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign sp_a[g] = setpoint[g*DATA_W +: DATA_W];
    assign ms_a[g] = meas[g*DATA_W +: DATA_W];
    assign pid_out[g*DATA_W +: DATA_W] = pid_r[g];
  end

  function automatic logic signed [DATA_W-1:0] sat_err(input logic signed [DATA_W:0] x);
    logic signed [DATA_W-1:0] r;
    if (x > (DATA_W+1)'(D_MAX)) r = D_MAX;
    else if (x < (DATA_W+1)'(D_MIN)) r = D_MIN;
    else r = x[DATA_W-1:0];
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_int(input logic signed [PROD_W:0] x);
    logic signed [DATA_W-1:0] r;
    if (x > (PROD_W+1)'(INT_LIM)) r = INT_LIM;
    else if (x < (PROD_W+1)'(NEG_LIM)) r = NEG_LIM;
    else r = x[DATA_W-1:0];
    return r;
  endfunction

  assign sp_s         = sp_a[ch_r];
  assign ms_s         = ms_a[ch_r];
  assign en_s         = ch_en[ch_r];
  assign integ_s      = integ_r[ch_r];
  assign prev_s       = prev_err_r[ch_r];
  assign err_full_s   = $signed({1'b0, sp_s}) - $signed({1'b0, ms_s});
  assign diff_s       = {err_r[DATA_W-1], err_r} - {prev_s[DATA_W-1], prev_s};
  assign prod_s       = PROD_W'(mul_a_s) * PROD_W'(mul_b_s);
  assign shift_s      = prod_s >>> FRAC_BITS;
  assign icand_full_s = (PROD_W+1)'(integ_s) + (PROD_W+1)'(shift_s);
  assign sum_s        = SUM_W'(p_r) + SUM_W'(icand_r) + SUM_W'(d_r);
  // Integrator is frozen when it would push further into the active clamp.
  assign hold_s       = (sat_hi_r && (icand_r > integ_s)) || (sat_lo_r && (icand_r < integ_s));

  // Operand select for the shared multiplier: one product per P/I/D phase.
  always_comb begin
    mul_a_s = kp;
    mul_b_s = {err_r[DATA_W-1], err_r};
    case (state_r)
      S_I: begin
        mul_a_s = ki;
        mul_b_s = {err_r[DATA_W-1], err_r};
      end
      S_D: begin
        mul_a_s = kd;
        mul_b_s = diff_s;
      end
      default: begin
        mul_a_s = kp;
        mul_b_s = {err_r[DATA_W-1], err_r};
      end
    endcase
  end

  // Sweep sequencer, datapath pipeline registers and per-channel state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= S_IDLE;
      ch_r      <= '0;
      en_r      <= 1'b0;
      err_r     <= '0;
      icand_r   <= '0;
      sum_r     <= '0;
      p_r       <= '0;
      d_r       <= '0;
      sat_hi_r  <= 1'b0;
      sat_lo_r  <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        integ_r[k]    <= '0;
        prev_err_r[k] <= '0;
        pid_r[k]      <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (sample_tick && (state_r != S_IDLE)) overrun <= 1'b1;
      else overrun <= overrun;
      case (state_r)
        S_IDLE: begin
          if (sample_tick) begin
            state_r <= S_ERR;
            ch_r    <= '0;
            busy    <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ERR: begin
          err_r   <= sat_err(err_full_s);
          en_r    <= en_s;
          state_r <= S_P;
        end
        S_P: begin
          p_r     <= shift_s;
          state_r <= S_I;
        end
        S_I: begin
          icand_r <= sat_int(icand_full_s);
          state_r <= S_D;
        end
        S_D: begin
          d_r     <= shift_s;
          state_r <= S_SUM;
        end
        S_SUM: begin
          if (sum_s > SUM_W'(out_max)) begin
            sum_r    <= out_max;
            sat_hi_r <= 1'b1;
            sat_lo_r <= 1'b0;
          end else if (sum_s < SUM_W'(out_min)) begin
            sum_r    <= out_min;
            sat_hi_r <= 1'b0;
            sat_lo_r <= 1'b1;
          end else begin
            sum_r    <= sum_s[DATA_W-1:0];
            sat_hi_r <= 1'b0;
            sat_lo_r <= 1'b0;
          end
          state_r <= S_WR;
        end
        S_WR: begin
          if (en_r) begin
            pid_r[ch_r]      <= sum_r;
            prev_err_r[ch_r] <= err_r;
            if (!hold_s) integ_r[ch_r] <= icand_r;
            else integ_r[ch_r] <= integ_s;
          end else begin
            pid_r[ch_r]      <= '0;
            prev_err_r[ch_r] <= '0;
            integ_r[ch_r]    <= '0;
          end
          out_valid <= 1'b1;
          out_ch    <= ch_r;
          if (ch_r == CH_W'(N_CH - 1)) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            ch_r    <= ch_r + 1'b1;
            state_r <= S_ERR;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_multi_channel.sv
// Directed bench for pid_multi_channel: a per-sweep arithmetic model plus a cycle-by-cycle compare.
module tb_pid_multi_channel;
  localparam int N  = 4;
  localparam int DW = 16;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic sample_tick = 1'b0;
  logic [N-1:0] ch_en = '0;
  logic [N*DW-1:0] setpoint, meas, pid_out;
  logic signed [15:0] kp = '0, ki = '0, kd = '0;
  logic signed [15:0] out_min = -16'sd32767, out_max = 16'sd32767;
  logic out_valid, busy, overrun;
  logic [1:0] out_ch;
  int sp_v[N];
  int ms_v[N];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  bit active = 1'b0;
  bit exp_ovr = 1'b0;
  longint m_integ[N], m_prev[N], m_out[N], committed[N];
  longint exp_vec[N][N];

  pid_multi_channel dut (
    .CLK(CLK), .RESET(RESET), .sample_tick(sample_tick), .ch_en(ch_en),
    .setpoint(setpoint), .meas(meas), .kp(kp), .ki(ki), .kd(kd),
    .out_min(out_min), .out_max(out_max), .pid_out(pid_out),
    .out_valid(out_valid), .out_ch(out_ch), .busy(busy), .overrun(overrun)
  );

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign setpoint[g*DW +: DW] = sp_v[g][DW-1:0];
    assign meas[g*DW +: DW]     = ms_v[g][DW-1:0];
  end

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint dut_ch(input int c);
    return longint'($signed(pid_out[c*DW +: DW]));
  endfunction

  function automatic longint fdiv128(input longint x);
    longint q = x / 128;
    if ((x % 128 != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint x, input longint lo, input longint hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_integ[c] = 0; m_prev[c] = 0; m_out[c] = 0; committed[c] = 0;
    end
    active = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Whole-sweep result from the control law; exp_vec[c] is pid_out after channel c's write.
  task automatic model_sweep();
    longint e, p, ic, d, s, kpv, kiv, kdv;
    kpv = kp; kiv = ki; kdv = kd;
    for (int c = 0; c < N; c++) begin
      e = clampv(longint'(sp_v[c]) - longint'(ms_v[c]), -32768, 32767);
      if (!ch_en[c]) begin
        m_out[c] = 0; m_integ[c] = 0; m_prev[c] = 0;
      end else begin
        p  = fdiv128(kpv * e);
        ic = clampv(m_integ[c] + fdiv128(kiv * e), -20000, 20000);
        d  = fdiv128(kdv * (e - m_prev[c]));
        s  = p + ic + d;
        m_out[c] = clampv(s, out_min, out_max);
        if (!((s > out_max && ic > m_integ[c]) || (s < out_min && ic < m_integ[c])))
          m_integ[c] = ic;
        m_prev[c] = e;
      end
      for (int k = 0; k < N; k++) exp_vec[c][k] = m_out[k];
    end
  endtask

  // Per-cycle comparison of every output against the model schedule.
  always @(negedge CLK) begin
    int rel;
    bit ev, eb;
    if (RESET) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_out_ch", out_ch, 0);
      for (int c = 0; c < N; c++) chk("rst_pid_out", dut_ch(c), 0);
    end else begin
      rel = cyc - t0;
      ev = active && rel >= 6 && rel <= 6*N && (rel % 6 == 0);
      eb = active && rel >= 0 && rel < 6*N;
      chk("out_valid", out_valid, ev);
      chk("busy", busy, eb);
      chk("overrun", overrun, exp_ovr);
      if (ev) begin
        for (int k = 0; k < N; k++) committed[k] = exp_vec[rel/6-1][k];
        chk("out_ch", out_ch, rel/6 - 1);
      end
      for (int c = 0; c < N; c++) chk("pid_out", dut_ch(c), committed[c]);
    end
  end

  task automatic step();
    @(posedge CLK); #2;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_reset();
    step();
    RESET = 1'b0;
  endtask

  task automatic do_tick();
    bit ovr;
    ovr = active && (cyc - t0 >= 0) && (cyc - t0 < 6*N);
    if (!ovr) begin
      t0 = cyc + 1;
      active = 1'b1;
      model_sweep();
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    if (ovr) exp_ovr = 1'b1;
  endtask

  task automatic sweep();
    do_tick();
    wait_until(t0 + 6*N + 1);
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin sp_v[c] = 0; ms_v[c] = 0; end
    model_reset();
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b0;

    // single step and second tick
    kp = 16'sd205; ki = 16'sd32; kd = 16'sd77;
    ch_en = 4'b0001; sp_v[0] = 900; ms_v[0] = 400;
    sweep();
    chk("step1_model", m_out[0], 1225);
    chk("step1_dut", dut_ch(0), 1225);
    sweep();
    chk("step2_dut", dut_ch(0), 1050);
    chk("step2_integ", m_integ[0], 250);

    // negative error, floor rounding
    do_reset();
    sp_v[0] = 400; ms_v[0] = 900;
    sweep();
    chk("neg_floor", dut_ch(0), -1227);

    // anti-windup
    do_reset();
    sp_v[0] = 900; ms_v[0] = 400; out_max = 16'sd1000;
    sweep();
    chk("aw1_out", dut_ch(0), 1000);
    chk("aw1_integ", m_integ[0], 0);
    sweep();
    chk("aw2_out", dut_ch(0), 925);
    chk("aw2_integ", m_integ[0], 125);

    // multi-channel with a channel disabled on the second sweep
    do_reset();
    out_max = 16'sd32767; ch_en = 4'b1111;
    sp_v[0] = 900;  ms_v[0] = 400; sp_v[1] = 1000; ms_v[1] = 200;
    sp_v[2] = 600;  ms_v[2] = 500; sp_v[3] = 300;  ms_v[3] = 700;
    sweep();
    chk("mc_ch1", dut_ch(1), 1962);
    chk("mc_ch2", dut_ch(2), 245);
    chk("mc_ch3", dut_ch(3), -982);
    ch_en = 4'b1011;
    sweep();
    chk("mc_ch2_off", dut_ch(2), 0);
    chk("mc_busy_low", busy, 0);

    // overrun mid-sweep, then reset abort and restart
    do_tick();
    wait_until(t0 + 2);
    do_tick();
    chk("ovr_set", overrun, 1);
    wait_until(t0 + 10);
    do_reset();
    chk("ovr_cleared", overrun, 0);
    chk("abort_ch0", dut_ch(0), 0);
    sweep();
    // tick coinciding with the final WR cycle
    do_tick();
    wait_until(t0 + 6*N - 1);
    do_tick();
    wait_until(t0 + 6*N + 2);
    chk("ovr_final_wr", overrun, 1);

    // error and integral saturation
    do_reset();
    kp = 16'sd128; ki = 16'sd0; kd = 16'sd0;
    ch_en = 4'b0001; sp_v[0] = 65535; ms_v[0] = 0;
    sweep();
    chk("esat_out", dut_ch(0), 32767);
    kp = 16'sd0; ki = 16'sd128;
    sweep();
    chk("isat1", dut_ch(0), 20000);
    sweep();
    chk("isat2", dut_ch(0), 20000);
    sp_v[0] = 0; ms_v[0] = 65535;
    sweep();
    chk("isat_neg1", dut_ch(0), -12768);
    sweep();
    chk("isat_neg2", dut_ch(0), -20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
